mant_divider: RTL and testbench
===============================

Name: mant_divider

Overview:
- Parametrised sequential restoring divider for floating-point mantissas with hidden 1: computes {1,dividend_frac} / {1,divisor_frac}, one quotient bit per clock.
- Successor to the fixed 23-bit divider. Adds configurable width, a start/busy/done handshake, a sticky bit and a normalisation flag, plus optional early termination.
- Sits in the FP divide datapath between exponent/sign handling and the normalise/round stage.

Parameters:
- FRAC_W, 23, mantissa fraction width (hidden bit excluded); 23 = single, 52 = double.
- Q_W, FRAC_W+2, quotient width: 1 integer bit + (Q_W-1) fraction bits; must be >= FRAC_W+2.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- dividend_frac  in  FRAC_W  dividend fraction; hidden 1 implied.
- divisor_frac  in  FRAC_W  divisor fraction; hidden 1 implied.
- busy  out  1  division in progress.
- done  out  1  one-cycle pulse when quotient/sticky/lt_one are valid.
- quotient  out  Q_W  bit Q_W-1 = integer bit; rest fraction, truncated.
- sticky  out  1  1 if final remainder is non-zero (inexact).
- lt_one  out  1  quotient < 1 (quotient[Q_W-1]=0); downstream shifts left 1, exponent -1.

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (n_rst). Reset forces state IDLE and sets busy, done, quotient, sticky, lt_one, the counter and internal registers to 0.
- States:
  - IDLE: start=1 latches D={1,dividend_frac} into rem (FRAC_W+2 bits), V={1,divisor_frac}, clears quotient, cnt=0, then goes to CALC.
  - CALC: each edge: if rem>=V, q bit=1 and rem=(rem-V)<<1; else q bit=0 and rem=rem<<1. Bit shifts into quotient LSB (MSB first). cnt++. On the edge where cnt reaches Q_W-1, the last bit is produced and the state goes to DONE.
  - DONE: lasts one cycle; done=1, busy=0. Next edge goes to IDLE, or straight to CALC with new operands if start=1 (back-to-back).
- busy=1 exactly while in CALC.
- Arithmetic: rem invariant rem < 2V <= 4, so FRAC_W+2 bits never overflow. The quotient lies in (0.5, 2), so quotient[Q_W-1:Q_W-2] is never 00.
- Latency: start sampled at edge 0 gives done high after edge Q_W (25 cycles by default). Throughput is one result per Q_W+1 cycles.
- Output timing:
  - sticky = (rem != 0) and lt_one = ~quotient[Q_W-1] are registered at the same edge done rises.
  - quotient, sticky and lt_one hold until the next accepted start, then clear.
- Boundary conditions:
  - start while busy: ignored, operands not resampled.
  - Operand changes during CALC: no effect.
  - Divide-by-zero cannot occur (hidden 1).
  - Reset mid-CALC aborts immediately; no done pulse.

Optional Feature:
- Macro MANT_DIV_EARLY_TERM_EN.
- Defined:
  - In CALC, if the updated rem is 0 after producing a bit, the remaining quotient bits are zero-filled (quotient shifted left by the bits remaining).
  - State goes to DONE on that same edge, with sticky=0.
  - Latency becomes k cycles, where k = number of bits needed (1..Q_W).
- Undefined: fixed Q_W-cycle latency always.
- Results are bit-identical either way; only timing differs.

Test Plan:
- dividend_frac=23'h400000, divisor_frac=0 (1.5/1.0) -> done after 25 cycles; quotient=25'h1800000, sticky=0, lt_one=0. With EARLY_TERM_EN: done after 2 cycles, same values.
- 23'h0 / 23'h400000 (1.0/1.5) -> quotient=25'h0AAAAAA, sticky=1, lt_one=1; 25 cycles in both builds.
- 23'h7FFFFF / 23'h0 ((2-2^-23)/1) -> quotient=25'h1FFFFFE, sticky=0; 23'h600000/23'h600000 -> quotient=25'h1000000, sticky=0.
- Handshake: start held high continuously -> results back-to-back every 26 cycles. A start pulse mid-CALC with new operands is ignored and the result matches the first operands. busy=1 for exactly 25 cycles.
- n_rst=0 at cycle 10 of CALC -> all outputs 0 immediately, no done pulse; a new start after release gives a correct result.
- Random 10k pairs vs real-number model (quotient = floor(D/V*2^(Q_W-1)), sticky = inexact), with FRAC_W=23 and FRAC_W=52, both macro settings.

Source files
------------

// File: rtl/mant_divider.sv
// Sequential restoring divider for hidden-1 mantissas: one quotient bit per clock, MSB first.
// Optional early termination on a zero remainder is enabled by defining MANT_DIV_EARLY_TERM_EN.
`timescale 1ns/1ps
module mant_divider #(
    parameter int FRAC_W = 23,
    parameter int Q_W    = FRAC_W + 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [FRAC_W-1:0] dividend_frac,
    input  logic [FRAC_W-1:0] divisor_frac,
    output logic              busy,
    output logic              done,
    output logic [Q_W-1:0]    quotient,
    output logic              sticky,
    output logic              lt_one
);

    localparam int R_W   = FRAC_W + 2;
    localparam int CNT_W = $clog2(Q_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [R_W-1:0]     rem_q, rem_d;
    logic [R_W-1:0]     div_q, div_d;
    logic [Q_W-1:0]     quot_q, quot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sticky_q, sticky_d;
    logic               lt_one_q, lt_one_d;

    logic               ge;
    logic [R_W-1:0]     diff;
    logic [R_W-1:0]     rem_next;
    logic [Q_W-1:0]     quot_shift;
    logic               finish;
`ifdef MANT_DIV_EARLY_TERM_EN
    logic [CNT_W-1:0]   fill_sh;
`endif

    // rem < 2V always holds, so the shifted partial remainder never needs an extra bit.
    always_comb begin
        ge         = (rem_q >= div_q);
        diff       = rem_q - div_q;
        rem_next   = ge ? (diff << 1) : (rem_q << 1);
        quot_shift = {quot_q[Q_W-2:0], ge};
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quot_d   = quot_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        lt_one_d = lt_one_q;
        finish   = 1'b0;
`ifdef MANT_DIV_EARLY_TERM_EN
        fill_sh  = CNT_W'(Q_W - 1) - cnt_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    rem_d    = {2'b01, dividend_frac};
                    div_d    = {2'b01, divisor_frac};
                    quot_d   = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                    lt_one_d = 1'b0;
                    state_d  = CALC;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d  = rem_next;
                quot_d = quot_shift;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(Q_W - 1)) begin
                    finish = 1'b1;
                end
`ifdef MANT_DIV_EARLY_TERM_EN
                // Exact result reached: the bits not yet produced are all zero.
                if (rem_next == '0) begin
                    quot_d = quot_shift << fill_sh;
                    finish = 1'b1;
                end
`endif
                if (finish) begin
                    sticky_d = (rem_next != '0);
                    lt_one_d = ~quot_d[Q_W-1];
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            div_q    <= '0;
            quot_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            lt_one_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quot_q   <= quot_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            lt_one_q <= lt_one_d;
        end
    end

    assign busy     = (state_q == CALC);
    assign done     = (state_q == DONE);
    assign quotient = quot_q;
    assign sticky   = sticky_q;
    assign lt_one   = lt_one_q;

endmodule

// File: tb/tb_mant_divider.sv
// Self-checking bench for mant_divider: directed, random, handshake and reset scenarios
// compared against an arithmetic reference (integer division of the scaled mantissas).
`timescale 1ns/1ps
module tb_mant_divider;

    localparam int FRAC_W = 23;
    localparam int Q_W    = FRAC_W + 2;
    localparam int WW     = FRAC_W + Q_W + 2;
    localparam int N_RAND = 300;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start = 1'b0;
    logic [FRAC_W-1:0] dividend_frac = '0;
    logic [FRAC_W-1:0] divisor_frac = '0;
    logic              busy;
    logic              done;
    logic [Q_W-1:0]    quotient;
    logic              sticky;
    logic              lt_one;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mant_divider #(.FRAC_W(FRAC_W), .Q_W(Q_W)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .dividend_frac (dividend_frac),
        .divisor_frac  (divisor_frac),
        .busy          (busy),
        .done          (done),
        .quotient      (quotient),
        .sticky        (sticky),
        .lt_one        (lt_one)
    );

    // Reference: q = floor(D/V * 2^(Q_W-1)), sticky = inexact, latency from divisibility.
    function automatic void ref_div(input logic [FRAC_W-1:0] a, input logic [FRAC_W-1:0] b,
                                    output logic [Q_W-1:0] q, output logic st, output int lat);
        logic [WW-1:0] d, v, num;
        d   = WW'({1'b1, a});
        v   = WW'({1'b1, b});
        num = d << (Q_W - 1);
        q   = Q_W'(num / v);
        st  = ((num % v) != 0);
        lat = Q_W;
`ifdef MANT_DIV_EARLY_TERM_EN
        for (int k = 1; k <= Q_W; k++) begin
            if (((d << (k - 1)) % v) == 0) begin
                lat = k;
                break;
            end
        end
`endif
    endfunction

    function automatic logic [FRAC_W-1:0] rand_frac();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[FRAC_W-1:0];
    endfunction

    // Launches one division and waits (bounded) for done; lat = 0 means no done seen.
    task automatic run_div(input logic [FRAC_W-1:0] a, input logic [FRAC_W-1:0] b,
                           output logic [Q_W-1:0] q, output logic st, output logic lt,
                           output int lat, output int bcnt);
        @(negedge clk);
        dividend_frac = a;
        divisor_frac  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        lat  = 0;
        q = '0; st = 1'b0; lt = 1'b0;
        for (int c = 1; c <= Q_W + 5; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                q = quotient; st = sticky; lt = lt_one;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, quotient, sticky, lt_one} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h st=%b lt=%b, expected all 0",
                     busy, done, quotient, sticky, lt_one);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [FRAC_W-1:0] ta [4];
        logic [FRAC_W-1:0] tb [4];
        logic [Q_W-1:0]    tq [4];
        logic              ts [4];
        logic              tl [4];
        logic [Q_W-1:0] q, rq;
        logic st, lt, rst_;
        int lat, bcnt, rlat;
        ta[0] = 23'h400000; tb[0] = 23'h000000; tq[0] = 25'h1800000; ts[0] = 1'b0; tl[0] = 1'b0;
        ta[1] = 23'h000000; tb[1] = 23'h400000; tq[1] = 25'h0AAAAAA; ts[1] = 1'b1; tl[1] = 1'b1;
        ta[2] = 23'h7FFFFF; tb[2] = 23'h000000; tq[2] = 25'h1FFFFFE; ts[2] = 1'b0; tl[2] = 1'b0;
        ta[3] = 23'h600000; tb[3] = 23'h600000; tq[3] = 25'h1000000; ts[3] = 1'b0; tl[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ref_div(ta[i], tb[i], rq, rst_, rlat);
            run_div(ta[i], tb[i], q, st, lt, lat, bcnt);
            tests_run++;
            if (lat !== rlat) begin
                tests_failed++;
                $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, rlat);
            end
            tests_run++;
            if (bcnt !== rlat) begin
                tests_failed++;
                $display("FAIL directed%0d_busy_cycles: got %0d expected %0d", i, bcnt, rlat);
            end
            tests_run++;
            if ({q, st, lt} !== {tq[i], ts[i], tl[i]}) begin
                tests_failed++;
                $display("FAIL directed%0d_result: got q=%h st=%b lt=%b expected q=%h st=%b lt=%b",
                         i, q, st, lt, tq[i], ts[i], tl[i]);
            end
        end
        // Directed rate of quotient model is the only variable part of latency in these cases.
        tests_run++;
        if (rlat !== 1 && rlat !== Q_W) begin
            tests_failed++;
            $display("FAIL directed_exact_latency: got %0d expected 1 or %0d", rlat, Q_W);
        end
    endtask

    task automatic test_hold();
        logic [Q_W-1:0] q, rq;
        logic st, lt, rst_;
        int lat, bcnt, rlat;
        logic [FRAC_W-1:0] a, b;
        a = rand_frac();
        b = rand_frac();
        ref_div(a, b, rq, rst_, rlat);
        run_div(a, b, q, st, lt, lat, bcnt);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({done, busy, quotient, sticky, lt_one} !== {1'b0, 1'b0, rq, rst_, ~rq[Q_W-1]}) begin
            tests_failed++;
            $display("FAIL hold_outputs: got done=%b busy=%b q=%h st=%b lt=%b expected 0 0 q=%h st=%b lt=%b",
                     done, busy, quotient, sticky, lt_one, rq, rst_, ~rq[Q_W-1]);
        end
    endtask

    task automatic test_random();
        logic [Q_W-1:0] q, rq;
        logic st, lt, rst_;
        int lat, bcnt, rlat;
        logic [FRAC_W-1:0] a, b;
        for (int i = 0; i < N_RAND; i++) begin
            a = rand_frac();
            b = (i % 10 == 0) ? a : rand_frac();
            ref_div(a, b, rq, rst_, rlat);
            run_div(a, b, q, st, lt, lat, bcnt);
            tests_run++;
            if ({q, st, lt} !== {rq, rst_, ~rq[Q_W-1]} || lat !== rlat) begin
                tests_failed++;
                $display("FAIL random%0d %h/%h: got q=%h st=%b lt=%b lat=%0d expected q=%h st=%b lt=%b lat=%0d",
                         i, a, b, q, st, lt, lat, rq, rst_, ~rq[Q_W-1], rlat);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [Q_W-1:0] rq;
        logic rst_;
        int rlat, lat;
        ref_div(23'h000000, 23'h400000, rq, rst_, rlat);
        @(negedge clk);
        dividend_frac = 23'h000000;
        divisor_frac  = 23'h400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        dividend_frac = 23'h7FFFFF;
        divisor_frac  = 23'h123456;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int c = 1; c <= Q_W + 5; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        tests_run++;
        if (lat == 0 || {quotient, sticky, lt_one} !== {rq, rst_, ~rq[Q_W-1]}) begin
            tests_failed++;
            $display("FAIL ignore_start: got q=%h st=%b lt=%b done_seen=%0d expected q=%h st=%b lt=%b",
                     quotient, sticky, lt_one, lat, rq, rst_, ~rq[Q_W-1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [Q_W-1:0] rqa, rqb, q1, q2;
        logic sta, stb, s1, s2;
        int la, lb, d1, d2;
        logic [FRAC_W-1:0] bd, bv;
        bd = rand_frac();
        bv = rand_frac();
        ref_div(23'h000000, 23'h400000, rqa, sta, la);
        ref_div(bd, bv, rqb, stb, lb);
        @(negedge clk);
        dividend_frac = 23'h000000;
        divisor_frac  = 23'h400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        dividend_frac = bd;
        divisor_frac  = bv;
        d1 = 0; d2 = 0;
        q1 = '0; q2 = '0; s1 = 1'b0; s2 = 1'b0;
        for (int c = 1; c <= 3 * Q_W; c++) begin
            @(posedge clk);
            #1;
            if (d1 != 0 && c == d1 + 1) start = 1'b0;
            if (done) begin
                if (d1 == 0) begin
                    d1 = c; q1 = quotient; s1 = sticky;
                end else begin
                    d2 = c; q2 = quotient; s2 = sticky;
                    break;
                end
            end
        end
        start = 1'b0;
        tests_run++;
        if (d1 !== la || d2 !== la + 1 + lb) begin
            tests_failed++;
            $display("FAIL b2b_timing: got done at %0d,%0d expected %0d,%0d", d1, d2, la, la + 1 + lb);
        end
        tests_run++;
        if ({q1, s1, q2, s2} !== {rqa, sta, rqb, stb}) begin
            tests_failed++;
            $display("FAIL b2b_results: got %h/%b %h/%b expected %h/%b %h/%b",
                     q1, s1, q2, s2, rqa, sta, rqb, stb);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [Q_W-1:0] q, rq;
        logic st, lt, rst_;
        int lat, bcnt, rlat, seen;
        @(negedge clk);
        dividend_frac = 23'h000000;
        divisor_frac  = 23'h400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, quotient, sticky, lt_one} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_calc: got busy=%b done=%b q=%h st=%b lt=%b, expected all 0",
                     busy, done, quotient, sticky, lt_one);
        end
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (Q_W + 2) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: got %0d active cycles expected 0", seen);
        end
        ref_div(23'h2AAAAA, 23'h555555, rq, rst_, rlat);
        run_div(23'h2AAAAA, 23'h555555, q, st, lt, lat, bcnt);
        tests_run++;
        if ({q, st, lt} !== {rq, rst_, ~rq[Q_W-1]} || lat !== rlat) begin
            tests_failed++;
            $display("FAIL after_reset_result: got q=%h st=%b lt=%b lat=%0d expected q=%h st=%b lt=%b lat=%0d",
                     q, st, lt, lat, rq, rst_, ~rq[Q_W-1], rlat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_ignore_start();
        test_back_to_back();
        repeat (Q_W + 3) @(posedge clk);
        test_reset_mid_calc();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
